// File: rtl/gcm_pkg.sv
// Shared types and length arithmetic for the AES-GCM phase sequencer.
// Optional feature macro: GCM_SEQ_PARTIAL_BLOCK_EN (partial last-block lengths).
package gcm_pkg;

  // Phase codes travel down the pipeline; bit 2 marks ciphertext-producing blocks.
  typedef enum logic [2:0] {
    PhIdle    = 3'b000,
    PhAad     = 3'b001,
    PhPayload = 3'b101,
    PhLength  = 3'b010,
    PhDrain   = 3'b011
  } gcm_phase_e;

  localparam int unsigned GCM_BLK_BITS = 128;
  localparam int unsigned GCM_LEN_W    = 64;

  // Bit length of a section of count blocks whose last block holds last_bytes
  // bytes (0 means a full 16-byte block). An empty section has length 0.
  function automatic logic [GCM_LEN_W-1:0] gcm_len_bits(input logic [GCM_LEN_W-1:0] count,
                                                        input logic [4:0]           last_bytes);
    logic [GCM_LEN_W-1:0] bytes;
    bytes = (last_bytes == 5'd0) ? GCM_LEN_W'(16) : GCM_LEN_W'(last_bytes);
    if (count == '0) begin
      return '0;
    end
    return ((count - GCM_LEN_W'(1)) << 7) + (bytes << 3);
  endfunction

endpackage

// File: rtl/gcm_phase_sequencer_if.sv
// Command, source handshake and pipeline-side signals of the GCM phase sequencer.
// master: host/DMA front end plus final stage; slave: the sequencer itself.
interface gcm_phase_sequencer_if #(
  parameter int unsigned MAX_BLK_W = 32
);
  logic                 i_start;
  logic [MAX_BLK_W-1:0] i_aad_blocks;
  logic [MAX_BLK_W-1:0] i_pt_blocks;
  logic [4:0]           i_aad_last_bytes;
  logic [4:0]           i_pt_last_bytes;
  logic                 i_src_valid;
  logic                 o_src_ready;
  logic                 o_blk_valid;
  logic [2:0]           o_phase;
  logic [127:0]         o_len_block;
  logic                 o_final;
  logic                 i_tag_ready;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_error;

  modport master (
    output i_start, i_aad_blocks, i_pt_blocks, i_aad_last_bytes, i_pt_last_bytes,
    output i_src_valid, i_tag_ready,
    input  o_src_ready, o_blk_valid, o_phase, o_len_block, o_final, o_busy, o_done, o_error
  );

  modport slave (
    input  i_start, i_aad_blocks, i_pt_blocks, i_aad_last_bytes, i_pt_last_bytes,
    input  i_src_valid, i_tag_ready,
    output o_src_ready, o_blk_valid, o_phase, o_len_block, o_final, o_busy, o_done, o_error
  );
endinterface

// File: rtl/gcm_blk_counter.sv
// Per-phase block down-counter: loads a block count, decrements per transfer,
// and flags the final block (count == 1).
module gcm_blk_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             is_last_o
);
  logic [Width-1:0] count_q, count_d;

  // Load wins over decrement; never wrap below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign is_last_o = (count_q == Width'(1));
endmodule

// File: rtl/gcm_phase_sequencer.sv
// AES-GCM phase sequencer: gates AAD and payload blocks into the pipeline,
// injects the len(A)||len(C) block and waits for the final-stage tag.
// Optional feature macro: GCM_SEQ_PARTIAL_BLOCK_EN (byte-accurate last-block lengths).
module gcm_phase_sequencer
  import gcm_pkg::*;
#(
  parameter int unsigned MAX_BLK_W   = 32,
  parameter int unsigned TAG_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  gcm_phase_sequencer_if.slave bus
);
  localparam int unsigned TimerW = (TAG_TIMEOUT > 1) ? $clog2(TAG_TIMEOUT) : 1;

  gcm_phase_e           state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic                 err_q, err_d;
  logic [127:0]         len_q, len_d;

  logic                 start_acc;
  logic                 src_ready;
  logic                 xfer;
  logic [MAX_BLK_W-1:0] aad_cnt, pt_cnt;
  logic                 aad_last, pt_last;
  logic [4:0]           aad_lb, pt_lb;
  logic [GCM_LEN_W-1:0] len_a, len_c;

`ifdef GCM_SEQ_PARTIAL_BLOCK_EN
  assign aad_lb = bus.i_aad_last_bytes;
  assign pt_lb  = bus.i_pt_last_bytes;
`else
  // A last-bytes code of 0 means a full block, giving whole-block lengths.
  assign aad_lb = 5'd0;
  assign pt_lb  = 5'd0;
`endif

  assign len_a = gcm_len_bits(GCM_LEN_W'(bus.i_aad_blocks), aad_lb);
  assign len_c = gcm_len_bits(GCM_LEN_W'(bus.i_pt_blocks), pt_lb);

  assign start_acc = bus.i_start && (state_q == PhIdle);
  assign src_ready = (state_q == PhAad) || (state_q == PhPayload);
  assign xfer      = bus.i_src_valid && src_ready;

  gcm_blk_counter #(.Width(MAX_BLK_W)) u_aad_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (start_acc),
    .load_val_i (bus.i_aad_blocks),
    .dec_i      (xfer && (state_q == PhAad)),
    .count_o    (aad_cnt),
    .is_last_o  (aad_last)
  );

  gcm_blk_counter #(.Width(MAX_BLK_W)) u_pt_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (start_acc),
    .load_val_i (bus.i_pt_blocks),
    .dec_i      (xfer && (state_q == PhPayload)),
    .count_o    (pt_cnt),
    .is_last_o  (pt_last)
  );

  // Next-state, timeout timer, sticky error and held length block.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    len_d   = len_q;
    unique case (state_q)
      PhIdle: begin
        if (start_acc) begin
          err_d = 1'b0;
          len_d = {len_a, len_c};
          if (bus.i_aad_blocks != '0) begin
            state_d = PhAad;
          end else if (bus.i_pt_blocks != '0) begin
            state_d = PhPayload;
          end else begin
            state_d = PhLength;
          end
        end
      end
      PhAad: begin
        if (xfer && aad_last) begin
          state_d = (pt_cnt != '0) ? PhPayload : PhLength;
        end
      end
      PhPayload: begin
        if (xfer && pt_last) begin
          state_d = PhLength;
        end
      end
      PhLength: begin
        state_d = PhDrain;
        timer_d = '0;
      end
      PhDrain: begin
        if (bus.i_tag_ready) begin
          state_d = PhIdle;
        end else if (timer_q == TimerW'(TAG_TIMEOUT - 1)) begin
          state_d = PhIdle;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: begin
        state_d = PhIdle;
      end
    endcase
  end

  // State registers; reset abandons any message in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PhIdle;
      timer_q <= '0;
      err_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  // Outputs: handshake and done are combinational so a stall leaves the pipe idle.
  always_comb begin
    bus.o_src_ready = src_ready;
    bus.o_blk_valid = xfer || (state_q == PhLength);
    bus.o_phase     = state_q;
    bus.o_final     = (state_q == PhLength);
    bus.o_busy      = (state_q != PhIdle);
    bus.o_done      = (state_q == PhDrain) && bus.i_tag_ready;
    bus.o_error     = err_q;
    bus.o_len_block = len_q;
  end

endmodule

// File: tb/tb_gcm_phase_sequencer.sv
// Scoreboard bench for gcm_phase_sequencer: the driver pushes the expected block
// stream and tag events per message; a negedge monitor pops and compares them.
module tb_gcm_phase_sequencer;
  localparam int unsigned MAX_BLK_W   = 32;
  localparam int unsigned TAG_TIMEOUT = 64;

  typedef struct {
    logic [2:0]   phase;
    logic         fin;
    logic [127:0] len;
  } exp_blk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_blk_t blk_q[$];
  int       done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gcm_phase_sequencer_if #(.MAX_BLK_W(MAX_BLK_W)) bus ();

  gcm_phase_sequencer #(
    .MAX_BLK_W   (MAX_BLK_W),
    .TAG_TIMEOUT (TAG_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Section length in bits from the block count and last-block byte count.
  function automatic logic [63:0] model_len(input int n, input int b);
    longint unsigned nb;
    if (n == 0) return 64'd0;
`ifdef GCM_SEQ_PARTIAL_BLOCK_EN
    nb = (b == 0) ? 16 : longint'(b);
    return 64'((longint'(n) - 1) * 128 + nb * 8);
`else
    nb = longint'(n) * 128;
    return 64'(nb);
`endif
  endfunction

  // Monitor: every issued block and every done pulse must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_blk_valid) begin
        if (blk_q.size() == 0) begin
          chk("unexpected_blk", bus.o_blk_valid, 1'b0);
        end else begin
          exp_blk_t e;
          e = blk_q.pop_front();
          chk("blk_phase", bus.o_phase, e.phase);
          chk("blk_final", bus.o_final, e.fin);
          chk("blk_len", bus.o_len_block, e.len);
        end
      end
      if (bus.o_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", bus.o_done, 1'b0);
        end else begin
          chk("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.i_start     = 1'b0;
    bus.i_src_valid = 1'b0;
    bus.i_tag_ready = 1'b0;
  endtask

  task automatic issue_start(input int aad, input int pt, output logic [127:0] len);
    int ab, pb;
    ab = $urandom_range(16, 0);
    pb = $urandom_range(16, 0);
    bus.i_start          = 1'b1;
    bus.i_aad_blocks     = MAX_BLK_W'(aad);
    bus.i_pt_blocks      = MAX_BLK_W'(pt);
    bus.i_aad_last_bytes = 5'(ab);
    bus.i_pt_last_bytes  = 5'(pb);
    len = {model_len(aad, ab), model_len(pt, pb)};
    for (int i = 0; i < aad; i++) blk_q.push_back('{3'b001, 1'b0, len});
    for (int i = 0; i < pt; i++) blk_q.push_back('{3'b101, 1'b0, len});
    blk_q.push_back('{3'b010, 1'b1, len});
  endtask

  // One message: vpct = % chance of offering a block per cycle; tag_delay < 0 = no tag.
  task automatic run_msg(input int aad, input int pt, input int vpct, input int tag_delay,
                         input bit noise);
    logic [127:0] len;
    int remaining, n, guard;
    @(posedge clk); #1;
    issue_start(aad, pt, len);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    remaining = aad + pt;
    guard = 0;
    while (remaining > 0 && guard < 2000) begin
      bus.i_src_valid = ($urandom_range(99, 0) < vpct);
      bus.i_start     = noise && ($urandom_range(9, 0) == 0);
      bus.i_tag_ready = noise && ($urandom_range(9, 0) == 0);
      bus.i_aad_blocks = MAX_BLK_W'($urandom_range(7, 0));
      bus.i_pt_blocks  = MAX_BLK_W'($urandom_range(7, 0));
      @(negedge clk);
      if (guard == 0) chk("err_cleared", bus.o_error, 1'b0);
      chk("src_ready_data", bus.o_src_ready, 1'b1);
      chk("busy_data", bus.o_busy, 1'b1);
      if (bus.i_src_valid) remaining--;
      guard++;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    chk("length_final", bus.o_final, 1'b1);
    chk("length_src_ready", bus.o_src_ready, 1'b0);
    @(posedge clk); #1;
    if (tag_delay >= 0) begin
      for (int i = 0; i < tag_delay; i++) begin
        @(negedge clk);
        chk("busy_drain", bus.o_busy, 1'b1);
        @(posedge clk); #1;
      end
      bus.i_tag_ready = 1'b1;
      done_q.push_back(cyc);
      @(posedge clk); #1;
      bus.i_tag_ready = 1'b0;
      @(negedge clk);
      chk("busy_after_done", bus.o_busy, 1'b0);
      chk("no_error_after_done", bus.o_error, 1'b0);
      chk("len_held", bus.o_len_block, len);
    end else begin
      n = 0;
      forever begin
        @(negedge clk);
        if (!bus.o_busy || n >= 4 * TAG_TIMEOUT) break;
        n++;
      end
      chk("drain_timeout_cycles", n, TAG_TIMEOUT);
      chk("timeout_error", bus.o_error, 1'b1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_src_ready"}, bus.o_src_ready, 1'b0);
    chk({tag, "_blk_valid"}, bus.o_blk_valid, 1'b0);
    chk({tag, "_final"}, bus.o_final, 1'b0);
    chk({tag, "_busy"}, bus.o_busy, 1'b0);
    chk({tag, "_done"}, bus.o_done, 1'b0);
    chk({tag, "_error"}, bus.o_error, 1'b0);
    chk({tag, "_len"}, bus.o_len_block, 128'd0);
    chk({tag, "_phase"}, bus.o_phase, 3'b000);
  endtask

  // Abort a message mid-payload with an asynchronous reset.
  task automatic reset_mid_payload();
    logic [127:0] len;
    @(posedge clk); #1;
    issue_start(2, 4, len);
    @(posedge clk); #1;
    bus.i_start     = 1'b0;
    bus.i_src_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    blk_q.delete();
    bus.i_src_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", bus.o_busy, 1'b0);
  endtask

  initial begin
    idle_inputs();
    bus.i_aad_blocks     = '0;
    bus.i_pt_blocks      = '0;
    bus.i_aad_last_bytes = '0;
    bus.i_pt_last_bytes  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    // Start pulsed while in reset must have no effect.
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release", bus.o_busy, 1'b0);

    run_msg(2, 3, 100, 10, 1'b0);
    run_msg(0, 0, 100, 3, 1'b0);
    run_msg(1, 2, 50, 0, 1'b0);
    run_msg(3, 4, 100, 5, 1'b1);
    run_msg(2, 1, 70, -1, 1'b0);
    run_msg(1, 0, 100, 2, 1'b0);
    run_msg(0, 3, 100, 1, 1'b1);
    for (int m = 0; m < 25; m++) begin
      int tag_delay;
      tag_delay = ($urandom_range(5, 0) == 0) ? -1 : int'($urandom_range(20, 0));
      run_msg(int'($urandom_range(5, 0)), int'($urandom_range(5, 0)),
              int'($urandom_range(100, 30)), tag_delay, 1'b1);
    end
    reset_mid_payload();
    run_msg(1, 1, 100, 4, 1'b0);

    repeat (3) @(posedge clk);
    chk("blk_queue_drained", blk_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gcm_phase_sequencer.md
# gcm_phase_sequencer

- Sequences one AES-GCM message through the AES/GHASH pipeline, ending in the final tag stage.
- Accepts a start command carrying AAD and payload block counts, then gates source blocks into the pipeline through a valid/ready handshake.
- Tags each issued block with its phase code, injects the len(A)||len(C) length block, and waits for the tag from the final stage.
- Sits between the host/DMA front end and stage 1 of the pipeline; `o_phase` travels down the pipeline alongside the data.

## Interface
Parameters:
- `MAX_BLK_W`, 32: width of the block-count inputs; legal range 1..57.
- `TAG_TIMEOUT`, 64: DRAIN cycles allowed before `o_error`; must be ≥ pipeline depth.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  command pulse; accepted only in IDLE.
- `i_aad_blocks`  in  MAX_BLK_W  number of AAD blocks; sampled on an accepted start.
- `i_pt_blocks`  in  MAX_BLK_W  number of payload blocks; sampled on an accepted start.
- `i_aad_last_bytes`  in  5  valid bytes in the last AAD block; 0 means 16.
- `i_pt_last_bytes`  in  5  valid bytes in the last payload block; 0 means 16.
- `i_src_valid`  in  1  source offers a block.
- `o_src_ready`  out  1  sequencer accepts a block this cycle.
- `o_blk_valid`  out  1  block enters pipeline stage 1 this cycle.
- `o_phase`  out  3  phase code of the block in flight.
- `o_len_block`  out  128  {len(A) bits[63:0], len(C) bits[63:0]}; this is the `instance_size` seen by the final stage.
- `o_final`  out  1  marks the length block; becomes the final stage's `ready` input.
- `i_tag_ready`  in  1  tag valid from the final stage.
- `o_busy`  out  1  sequencer is not in IDLE.
- `o_done`  out  1  one-cycle pulse when the tag is received.
- `o_error`  out  1  sticky; set by timeout, cleared by the next accepted start.

## Operation
State machine and phase codes:
- IDLE = 3'b000, AAD = 3'b001, PAYLOAD = 3'b101, LENGTH = 3'b010, DRAIN = 3'b011.
- `o_phase` is always the current state's code.
- Phase bit 2 set means a ciphertext-producing block; only PAYLOAD sets it.

Transitions:
- IDLE: on `i_start`, latch the counts, compute `o_len_block`, clear `o_error`.
- From IDLE the next state is AAD if aad>0, else PAYLOAD if pt>0, else LENGTH.
- AAD → PAYLOAD (or LENGTH if pt=0) on the transfer of the last AAD block.
- PAYLOAD → LENGTH on the transfer of the last payload block.
- LENGTH lasts exactly one cycle: `o_blk_valid`=1, `o_final`=1, no source transfer. Next state is DRAIN.
- DRAIN → IDLE when `i_tag_ready`=1; `o_done` pulses that same cycle.
- DRAIN → IDLE with `o_error`=1 and no `o_done` after `TAG_TIMEOUT` cycles without `i_tag_ready`.

Handshake:
- `o_src_ready` is 1 only in AAD and PAYLOAD.
- A transfer is `i_src_valid` & `o_src_ready`.
- Outside LENGTH, `o_blk_valid` equals the transfer; it is combinational from `i_src_valid`, and a stall leaves the pipeline idle.
- Each phase has a down-counter loaded with its block count; it decrements per transfer, and the last block is counter==1.

Length arithmetic:
- Without the macro: len(X) = 128·N, zero-extended to 64 bits.
- `o_len_block` is held from start until the next accepted start.

Boundary conditions:
- `i_start` while busy: ignored, with no effect on counters or outputs.
- `i_tag_ready` outside DRAIN: ignored.
- Both counts 0: IDLE → LENGTH → DRAIN, giving tag = E(J0) ^ GHASH(len).
- Reset asserted mid-message: immediate return to IDLE, counters cleared, no `o_done`. The source must restart the message.

## Timing
- Reset values:
  - 0: `o_src_ready`, `o_blk_valid`, `o_final`, `o_busy`, `o_done`, `o_error`, `o_len_block`.
  - `o_phase` = 3'b000.
- Start-to-first-ready: 1 cycle, since the state registers on the start edge.
- Throughput: one block per cycle when `i_src_valid` is held.
- Cycles from start to LENGTH = aad + pt + stall cycles + 1.
- `o_done` is registered-free: it follows `i_tag_ready` combinationally in DRAIN.
- `o_busy` drops in the cycle after `o_done`.

## Configuration
Macro: `GCM_SEQ_PARTIAL_BLOCK_EN`.
- Defined: len(X) = 128·(N−1) + 8·B for N>0, where B = last_bytes and 0 counts as 16; len(X) = 0 for N=0. The sequencer does not pad; the source zero-pads partial blocks.
- Undefined: the `*_last_bytes` inputs are ignored, and only whole-block lengths are supported.

## Structure
- Package `gcm_pkg`:
  - `gcm_phase_e`, a 3-bit enum holding the codes above.
  - `GCM_BLK_BITS`=128 and `GCM_LEN_W`=64.
  - function `gcm_len_bits(count, last_bytes)`.
- Sub-module `gcm_blk_counter` (load / decrement / is_last) is instantiated once per phase, twice in total.

## Test plan
- aad=2, pt=3, `i_src_valid`=1 constantly → phase sequence 001,001,101,101,101,010; `o_len_block`=0x…0100_…0180; `i_tag_ready` 10 cycles later → `o_done` pulse, IDLE.
- aad=0, pt=0 → LENGTH the cycle after start; `o_len_block`=0; `o_final`=1 for exactly 1 cycle.
- aad=1, pt=2, `i_src_valid` toggling 1,0,1,0,1 → exactly 3 transfers; `o_blk_valid` only on valid cycles; no extra blocks issued.
- Start during PAYLOAD, and `i_tag_ready` pulsed in AAD → both ignored; counts unchanged.
- No `i_tag_ready` in DRAIN → IDLE after 64 cycles with `o_error`=1 and no `o_done`; next start clears `o_error`.
- With the macro, aad=1/last 5, pt=2/last 0 → len(A)=40, len(C)=256. Separately, `rst_n` low mid-PAYLOAD → all outputs at reset values asynchronously.
